// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory loader.
//   - ADDR_W_DEFAULT : default instruction-memory word-address width
//   - MAX_WORDS      : largest load length accepted (2**ADDR_W_DEFAULT)
//   - BYTES_PER_WORD : stream bytes packed into one instruction word
//   - state_e        : loader FSM states
package imem_pkg;

    localparam int ADDR_W_DEFAULT = 10;
    localparam int MAX_WORDS      = 1 << ADDR_W_DEFAULT;
    localparam int BYTES_PER_WORD = 4;

    typedef enum logic [2:0] {
        IDLE,
        LEN_LO,
        LEN_HI,
        DATA,
        FIN
    } state_e;

endpackage

// File: rtl/word_packer.sv
// Packs a little-endian byte stream into 32-bit words.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   clr_i        : restart packing at byte index 0 with an empty word
//   byte_en_i    : byte_i is consumed this cycle
//   byte_i       : incoming stream byte
//   word_o       : word being assembled (complete when word_done_o is 1)
//   word_done_o  : one-cycle pulse, the cycle after the 4th byte of a word
module word_packer
    import imem_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr_i,
    input  logic        byte_en_i,
    input  logic [7:0]  byte_i,
    output logic [31:0] word_o,
    output logic        word_done_o
);

    localparam int IDX_W = $clog2(BYTES_PER_WORD);

    logic [IDX_W-1:0] idx_q, idx_d;
    logic [31:0]      shift_q, shift_d;
    logic             done_q, done_d;

    // NOTE: every variable gets a default before the branches so no path
    // leaves it unassigned; otherwise the tool infers a latch.
    always_comb begin
        idx_d   = idx_q;
        shift_d = shift_q;
        done_d  = 1'b0;
        if (clr_i) begin
            idx_d   = '0;
            shift_d = '0;
        end else if (byte_en_i) begin
            // New bytes enter at the top; after four shifts byte 0 sits in
            // bits [7:0], giving little-endian order.
            shift_d = {byte_i, shift_q[31:8]};
            idx_d   = idx_q + 1'b1;
            done_d  = (idx_q == IDX_W'(BYTES_PER_WORD - 1));
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values of the others.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q   <= '0;
            shift_q <= '0;
            done_q  <= 1'b0;
        end else begin
            idx_q   <= idx_d;
            shift_q <= shift_d;
            done_q  <= done_d;
        end
    end

    assign word_o      = shift_q;
    assign word_done_o = done_q;

endmodule

// File: rtl/imem_loader.sv
// Loads a CPU instruction memory from a byte stream.
// Stream format: 16-bit little-endian word count, then count*4 data bytes,
// each word little-endian. Words are written to consecutive addresses
// starting at 0.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   start               : begin a load (honoured only when idle)
//   abort               : cancel a load in progress, sets err
//   in_valid/in_byte    : byte stream source
//   in_ready            : loader can take a byte this cycle
//   mem_we/mem_addr/mem_wdata : instruction-memory write port
//   busy                : load in progress (CPU held in reset)
//   done                : one-cycle pulse on successful completion
//   err                 : sticky error, cleared by the next start
//   word_cnt            : words written in the current or last load
module imem_loader
    import imem_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEFAULT,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic              in_valid,
    input  logic [7:0]        in_byte,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   word_cnt
);

    localparam int unsigned LEN_MAX = 32'd1 << ADDR_W;

    state_e          state_q, state_d;
    logic [15:0]     len_q, len_d;
    logic [ADDR_W:0] word_cnt_q, word_cnt_d;
    logic            err_q, err_d;

    logic        accept;
    logic        abort_hit;
    logic        pk_clr, pk_en, pk_done;
    logic [31:0] pk_word;
    logic [15:0] len_full;
    logic        write_fire;

    assign accept     = in_valid && in_ready;
    assign abort_hit  = abort && (state_q != IDLE);
    // abort outranks start, so a simultaneous pair never opens a load.
    assign pk_clr     = start && !abort && (state_q == IDLE);
    assign pk_en      = accept && !abort && (state_q == DATA);
    assign write_fire = pk_done && !abort && (state_q == DATA);
    assign len_full   = {in_byte, len_q[7:0]};

    word_packer u_packer (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr_i      (pk_clr),
        .byte_en_i  (pk_en),
        .byte_i     (in_byte),
        .word_o     (pk_word),
        .word_done_o(pk_done)
    );

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        word_cnt_d = word_cnt_q;
        err_d      = err_q;

        unique case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    err_d      = 1'b0;
                    word_cnt_d = '0;
                    state_d    = LEN_LO;
                end
            end
            LEN_LO: begin
                if (accept) begin
                    len_d   = {8'h00, in_byte};
                    state_d = LEN_HI;
                end
            end
            LEN_HI: begin
                if (accept) begin
                    len_d = len_full;
                    if (len_full == 16'd0 || 32'(len_full) > LEN_MAX) begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end else begin
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                if (write_fire) begin
                    word_cnt_d = word_cnt_q + {{ADDR_W{1'b0}}, 1'b1};
                    // The word being written is the last one when the
                    // post-write count reaches len.
                    if (32'(word_cnt_q) + 32'd1 == 32'(len_q)) begin
                        state_d = FIN;
                    end
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (abort_hit) begin
            state_d = IDLE;
            err_d   = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            len_q      <= '0;
            word_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            word_cnt_q <= word_cnt_d;
            err_q      <= err_d;
        end
    end

    assign in_ready  = (state_q == LEN_LO) || (state_q == LEN_HI) || (state_q == DATA);
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == FIN) && !abort;
    assign mem_we    = write_fire;
    // Address is the pre-increment count, so word n lands at address n.
    assign mem_addr  = word_cnt_q[ADDR_W-1:0];
    assign mem_wdata = DATA_W'(pk_word);
    assign err       = err_q;
    assign word_cnt  = word_cnt_q;

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;
    import imem_pkg::*;

    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          in_valid = 1'b0;
    logic [7:0]    in_byte = 8'h00;
    logic          in_ready;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          busy;
    logic          done;
    logic          err;
    logic [AW:0]   word_cnt;

    imem_loader #(.ADDR_W(AW), .DATA_W(32)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .abort    (abort),
        .in_valid (in_valid),
        .in_byte  (in_byte),
        .in_ready (in_ready),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .word_cnt (word_cnt)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Write monitor: model memory plus write/done statistics.
    logic [31:0] tb_mem [0:MAX_WORDS-1];
    int wr_cnt = 0;
    int done_cnt = 0;
    int max_addr = -1;
    int seq_err = 0;

    always @(negedge clk) begin
        if (mem_we) begin
            if (int'(mem_addr) != wr_cnt) seq_err++;
            tb_mem[mem_addr] = mem_wdata;
            if (int'(mem_addr) > max_addr) max_addr = int'(mem_addr);
            wr_cnt++;
        end
        if (done) done_cnt++;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_stats();
        wr_cnt   = 0;
        done_cnt = 0;
        max_addr = -1;
        seq_err  = 0;
        for (int i = 0; i < MAX_WORDS; i++) tb_mem[i] = 32'h0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic pulse_abort();
        abort = 1'b1;
        tick();
        abort = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_byte  = b;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (!in_ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL ready_timeout: in_ready stayed 0 for byte 0x%0h", b);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_byte  = 8'h00;
        repeat (gap) tick();
    endtask

    task automatic send_word(input logic [31:0] w, input logic gaps);
        for (int k = 0; k < 4; k++) begin
            send_byte(w[8*k +: 8],
                      (gaps && $urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0);
        end
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < 40) begin
            n++;
            @(negedge clk);
        end
        check({name, "_idle"}, 64'(busy), 64'd0);
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        string       name;
        logic [7:0]  len_lo;
        logic [7:0]  len_hi;
        int          n_words;
        logic [31:0] w0;
        logic [31:0] w1;
        logic        exp_err;
        int          exp_cnt;
        int          exp_done;
    } vec_t;

    vec_t vecs [6];

    initial begin
        vecs[0] = '{"two_words", 8'h02, 8'h00, 2, 32'h0010_0493, 32'h0100_006f, 1'b0, 2, 1};
        vecs[1] = '{"len_zero",  8'h00, 8'h00, 0, 32'h0,         32'h0,         1'b1, 0, 0};
        vecs[2] = '{"len_1025",  8'h01, 8'h04, 0, 32'h0,         32'h0,         1'b1, 0, 0};
        vecs[3] = '{"one_word",  8'h01, 8'h00, 1, 32'hDEAD_BEEF, 32'h0,         1'b0, 1, 1};
        vecs[4] = '{"len_1281",  8'h01, 8'h05, 0, 32'h0,         32'h0,         1'b1, 0, 0};
        vecs[5] = '{"len_ffff",  8'hff, 8'hff, 0, 32'h0,         32'h0,         1'b1, 0, 0};

        // Reset state.
        #12;
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_mem_we",   64'(mem_we),   64'd0);
        check("rst_busy",     64'(busy),     64'd0);
        check("rst_done",     64'(done),     64'd0);
        check("rst_err",      64'(err),      64'd0);
        check("rst_outputs",  {mem_wdata, 21'(mem_addr), 11'(word_cnt)}, 64'd0);
        rst_n = 1'b1;
        tick();

        // Handshake levels around start.
        check("idle_in_ready", 64'(in_ready), 64'd0);
        pulse_start();
        check("lenlo_in_ready", 64'(in_ready), 64'd1);
        check("lenlo_busy",     64'(busy),     64'd1);
        pulse_abort();
        check("abort_lenlo_err",  64'(err),  64'd1);
        check("abort_lenlo_busy", 64'(busy), 64'd0);

        // Table-driven loads.
        for (int v = 0; v < 6; v++) begin
            clear_stats();
            pulse_start();
            send_byte(vecs[v].len_lo, 0);
            send_byte(vecs[v].len_hi, 0);
            if (vecs[v].n_words >= 1) send_word(vecs[v].w0, 1'b0);
            if (vecs[v].n_words >= 2) send_word(vecs[v].w1, 1'b0);
            wait_idle(vecs[v].name);
            check({vecs[v].name, "_err"},    64'(err),      64'(vecs[v].exp_err));
            check({vecs[v].name, "_cnt"},    64'(word_cnt), 64'(vecs[v].exp_cnt));
            check({vecs[v].name, "_writes"}, 64'(wr_cnt),   64'(vecs[v].exp_cnt));
            check({vecs[v].name, "_done"},   64'(done_cnt), 64'(vecs[v].exp_done));
            if (vecs[v].n_words >= 1) check({vecs[v].name, "_mem0"}, 64'(tb_mem[0]), 64'(vecs[v].w0));
            if (vecs[v].n_words >= 2) check({vecs[v].name, "_mem1"}, 64'(tb_mem[1]), 64'(vecs[v].w1));
        end

        // Abort while idle changes nothing (last table entry left err=1;
        // run a clean load first so err is 0).
        clear_stats();
        pulse_start();
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        send_word(32'h1234_5678, 1'b0);
        wait_idle("pre_idle_abort");
        pulse_abort();
        tick();
        check("idle_abort_err",  64'(err),      64'd0);
        check("idle_abort_busy", 64'(busy),     64'd0);
        check("idle_abort_cnt",  64'(word_cnt), 64'd1);

        // Full-size load with random stream gaps.
        clear_stats();
        pulse_start();
        send_byte(8'h00, 1);
        send_byte(8'h04, 2);
        for (int i = 0; i < MAX_WORDS; i++) begin
            send_word({16'(i) ^ 16'h5A5A, 16'(i)}, 1'b1);
        end
        wait_idle("full");
        begin
            int data_err;
            data_err = 0;
            for (int i = 0; i < MAX_WORDS; i++) begin
                if (tb_mem[i] !== {16'(i) ^ 16'h5A5A, 16'(i)}) data_err++;
            end
            check("full_data_errors", 64'(data_err), 64'd0);
        end
        check("full_writes",   64'(wr_cnt),   64'd1024);
        check("full_max_addr", 64'(max_addr), 64'h3FF);
        check("full_addr_seq", 64'(seq_err),  64'd0);
        check("full_done",     64'(done_cnt), 64'd1);
        check("full_cnt",      64'(word_cnt), 64'd1024);
        check("full_err",      64'(err),      64'd0);

        // start during DATA is ignored.
        clear_stats();
        pulse_start();
        send_byte(8'h02, 0);
        send_byte(8'h00, 0);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        pulse_start();
        send_byte(8'h33, 0);
        send_byte(8'h44, 0);
        send_word(32'h8877_6655, 1'b0);
        wait_idle("start_in_data");
        check("sid_writes", 64'(wr_cnt),    64'd2);
        check("sid_mem0",   64'(tb_mem[0]), 64'h4433_2211);
        check("sid_mem1",   64'(tb_mem[1]), 64'h8877_6655);
        check("sid_done",   64'(done_cnt),  64'd1);
        check("sid_cnt",    64'(word_cnt),  64'd2);

        // abort after 6 data bytes of a 3-word load.
        clear_stats();
        pulse_start();
        send_byte(8'h03, 0);
        send_byte(8'h00, 0);
        for (int k = 1; k <= 6; k++) send_byte(8'(k), 0);
        pulse_abort();
        wait_idle("abort6");
        check("abort6_writes", 64'(wr_cnt),    64'd1);
        check("abort6_mem0",   64'(tb_mem[0]), 64'h0403_0201);
        check("abort6_err",    64'(err),       64'd1);
        check("abort6_cnt",    64'(word_cnt),  64'd1);
        check("abort6_done",   64'(done_cnt),  64'd0);

        // abort on the exact write cycle suppresses the write.
        clear_stats();
        pulse_start();
        send_byte(8'h02, 0);
        send_byte(8'h00, 0);
        send_word(32'hA1B2_C3D4, 1'b0);
        pulse_abort();
        wait_idle("abort_we");
        check("abort_we_writes", 64'(wr_cnt),   64'd0);
        check("abort_we_cnt",    64'(word_cnt), 64'd0);
        check("abort_we_err",    64'(err),      64'd1);

        // Reset after 3 data bytes, then a fresh load.
        clear_stats();
        pulse_start();
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        send_byte(8'hAA, 0);
        send_byte(8'hBB, 0);
        send_byte(8'hCC, 0);
        rst_n = 1'b0;
        #1;
        check("mid_rst_in_ready", 64'(in_ready), 64'd0);
        check("mid_rst_busy",     64'(busy),     64'd0);
        check("mid_rst_err",      64'(err),      64'd0);
        check("mid_rst_mem_we",   64'(mem_we),   64'd0);
        check("mid_rst_outputs",  {mem_wdata, 21'(mem_addr), 11'(word_cnt)}, 64'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check("mid_rst_writes", 64'(wr_cnt), 64'd0);
        pulse_start();
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        send_word(32'hCAFE_F00D, 1'b0);
        wait_idle("post_rst");
        check("post_rst_writes", 64'(wr_cnt),    64'd1);
        check("post_rst_mem0",   64'(tb_mem[0]), 64'hCAFE_F00D);
        check("post_rst_done",   64'(done_cnt),  64'd1);
        check("post_rst_cnt",    64'(word_cnt),  64'd1);
        check("post_rst_err",    64'(err),       64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
